// File: rtl/sum_inv_enum.sv
// Inverse enumerator for the 4-bit "2*in1 + in2 + cin" adder cell: streams every (in1, in2) pair hitting a target sum.
// Optional self-check logic is built when SUM_INV_CHECK_EN is defined; otherwise chk_err is tied low.
module sum_inv_enum #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W:0]   req_sum,
  input  logic         req_cin,
  output logic         sol_valid,
  input  logic         sol_ready,
  output logic [W-1:0] sol_in1,
  output logic [W-1:0] sol_in2,
  output logic         sol_end,
  output logic [W:0]   sol_count,
  output logic         chk_err
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_HOLD, S_END} state_t;

  localparam logic [W-1:0] IDX_MAX = '1;

  state_t       r_state;
  state_t       w_next;
  logic [W:0]   r_sum;
  logic         r_cin;
  logic [W-1:0] r_idx;
  logic [W-1:0] r_in1;
  logic [W-1:0] r_in2;
  logic         r_valid;
  logic         r_end;
  logic [W:0]   r_count;
  logic [W:0]   w_d;
  logic         w_hit;
  logic         w_last;
  logic         w_hs;

  // Residual in2 for candidate in1; a set top bit means no W-bit in2 can reach the sum.
  function automatic logic [W:0] f_diff(input logic [W:0] s, input logic c, input logic [W-1:0] i);
    return s - {{W{1'b0}}, c} - {i, 1'b0};
  endfunction

  assign w_d    = f_diff(r_sum, r_cin, r_idx);
  assign w_hit  = ~w_d[W];
  assign w_last = (r_idx == IDX_MAX);
  assign w_hs   = r_valid & sol_ready;

  assign req_ready = (r_state == S_IDLE);
  assign sol_valid = r_valid;
  assign sol_in1   = r_in1;
  assign sol_in2   = r_in2;
  assign sol_end   = r_end;
  assign sol_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (req_valid) w_next = S_SEARCH;
      S_SEARCH: begin
        if (w_hit)       w_next = S_HOLD;
        else if (w_last) w_next = S_END;
      end
      S_HOLD:   if (w_hs) w_next = w_last ? S_END : S_SEARCH;
      S_END:    if (w_hs) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Request operands are only meaningful once captured, so they carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && req_valid) begin
      r_sum <= req_sum;
      r_cin <= req_cin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_in1   <= '0;
      r_in2   <= '0;
      r_valid <= 1'b0;
      r_end   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_idx   <= '0;
            r_count <= '0;
          end
        end
        S_SEARCH: begin
          if (w_hit) begin
            r_in1   <= r_idx;
            r_in2   <= w_d[W-1:0];
            r_valid <= 1'b1;
            r_end   <= 1'b0;
          end else if (w_last) begin
            r_in1   <= '0;
            r_in2   <= '0;
            r_valid <= 1'b1;
            r_end   <= 1'b1;
          end else begin
            r_idx <= r_idx + W'(1);
          end
        end
        S_HOLD: begin
          if (w_hs) begin
            r_count <= r_count + (W+1)'(1);
            if (w_last) begin
              r_in1 <= '0;
              r_in2 <= '0;
              r_end <= 1'b1;
            end else begin
              r_valid <= 1'b0;
              r_idx   <= r_idx + W'(1);
            end
          end
        end
        S_END: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            r_end   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SUM_INV_CHECK_EN
  localparam logic [W:0] EXP_CNT = (W+1)'(2**(W-1));

  logic r_chk;
  logic w_bad;

  function automatic logic [W:0] f_fwd(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return {a, 1'b0} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  always_comb begin
    w_bad = 1'b0;
    if (w_hs && r_state == S_HOLD) w_bad = (f_fwd(r_in1, r_in2, r_cin) != r_sum);
    if (w_hs && r_state == S_END)  w_bad = (r_count != EXP_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_chk <= 1'b0;
    else if (w_bad) r_chk <= 1'b1;
  end

  assign chk_err = r_chk;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_sum_inv_enum.sv
// Directed bench for sum_inv_enum: hand-computed operand lists, stall, busy-request, async reset and optional self-check.
module tb_sum_inv_enum;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [W:0]   req_sum;
  logic         req_cin;
  logic         sol_valid;
  logic         sol_ready;
  logic [W-1:0] sol_in1;
  logic [W-1:0] sol_in2;
  logic         sol_end;
  logic [W:0]   sol_count;
  logic         chk_err;

  int n_assert = 0;
  int n_fail   = 0;
  int e_in1[8];
  int e_in2[8];
  logic [3:0] pat = 4'b1001;

  sum_inv_enum #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sum(req_sum), .req_cin(req_cin),
    .sol_valid(sol_valid), .sol_ready(sol_ready),
    .sol_in1(sol_in1), .sol_in2(sol_in2),
    .sol_end(sol_end), .sol_count(sol_count),
    .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [W:0] s, input logic c);
    req_sum   = s;
    req_cin   = c;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Walk the response stream from the current negedge; stop_beat >= 0 parks the stream on that beat.
  task automatic collect(input bit toggle, input int stop_beat);
    int beat = 0;
    int cyc = 0;
    bit stalled = 0;
    bit done = 0;
    bit r;
    logic [W-1:0] h1, h2;
    logic [W:0]   hc;
    while (!done) begin
      if (cyc > 400) begin
        n_assert++;
        n_fail++;
        $error("FAIL timeout beats=%0d expected=9", beat);
        done = 1;
      end else begin
        r = toggle ? pat[cyc % 4] : 1'b1;
        if (sol_valid && beat == stop_beat) begin
          sol_ready = 1'b0;
          done = 1;
        end else begin
          sol_ready = r;
          chk("req_ready_busy", req_ready, 0);
          if (sol_valid) begin
            if (stalled) begin
              chk("stall_in1", sol_in1, h1);
              chk("stall_in2", sol_in2, h2);
              chk("stall_cnt", sol_count, hc);
            end
            if (r) begin
              if (beat < 8) begin
                chk("beat_in1", sol_in1, e_in1[beat]);
                chk("beat_in2", sol_in2, e_in2[beat]);
                chk("beat_end", sol_end, 0);
                chk("beat_cnt", sol_count, beat);
              end else begin
                chk("end_in1", sol_in1, 0);
                chk("end_in2", sol_in2, 0);
                chk("end_flag", sol_end, 1);
                chk("end_cnt", sol_count, 8);
                done = 1;
              end
              beat++;
              stalled = 0;
            end else begin
              stalled = 1;
              h1 = sol_in1;
              h2 = sol_in2;
              hc = sol_count;
            end
          end
        end
        cyc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic after_end();
    chk("post_valid", sol_valid, 0);
    chk("post_ready", req_ready, 1);
    chk("post_cnt", sol_count, 8);
    chk("post_chk", chk_err, 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_sum = '0;
    req_cin = 1'b0;
    sol_ready = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_valid", sol_valid, 0);
    chk("rst_in1", sol_in1, 0);
    chk("rst_in2", sol_in2, 0);
    chk("rst_end", sol_end, 0);
    chk("rst_cnt", sol_count, 0);
    chk("rst_chk", chk_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // sum=5 cin=0, ready high, with first-beat latency check
    e_in1 = '{0, 1, 2, 11, 12, 13, 14, 15};
    e_in2 = '{5, 3, 1, 15, 13, 11, 9, 7};
    sol_ready = 1'b1;
    issue(5'd5, 1'b0);
    chk("lat_valid_T", sol_valid, 0);
    chk("lat_ready_T", req_ready, 0);
    @(negedge clk);
    chk("lat_valid_T1", sol_valid, 1);
    collect(1'b0, -1);
    after_end();

    // sum=0 cin=0
    e_in1 = '{0, 9, 10, 11, 12, 13, 14, 15};
    e_in2 = '{0, 14, 12, 10, 8, 6, 4, 2};
    issue(5'd0, 1'b0);
    collect(1'b0, -1);
    after_end();

    // sum=0 cin=1 wraps to 31
    e_in1 = '{8, 9, 10, 11, 12, 13, 14, 15};
    e_in2 = '{15, 13, 11, 9, 7, 5, 3, 1};
    issue(5'd0, 1'b1);
    collect(1'b0, -1);
    after_end();

    // sum=5 with ready toggling and a competing request held while busy
    e_in1 = '{0, 1, 2, 11, 12, 13, 14, 15};
    e_in2 = '{5, 3, 1, 15, 13, 11, 9, 7};
    issue(5'd5, 1'b0);
    req_sum   = 5'd0;
    req_valid = 1'b1;
    collect(1'b1, -1);
    req_valid = 1'b0;
    after_end();

    // async reset while holding the 3rd beat, then sum=31 cin=1
    sol_ready = 1'b1;
    issue(5'd5, 1'b0);
    collect(1'b0, 2);
    chk("hold3_in1", sol_in1, 2);
    chk("hold3_valid", sol_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", sol_valid, 0);
    chk("arst_in1", sol_in1, 0);
    chk("arst_in2", sol_in2, 0);
    chk("arst_end", sol_end, 0);
    chk("arst_cnt", sol_count, 0);
    chk("arst_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    sol_ready = 1'b1;
    @(negedge clk);
    e_in1 = '{8, 9, 10, 11, 12, 13, 14, 15};
    e_in2 = '{14, 12, 10, 8, 6, 4, 2, 0};
    issue(5'd31, 1'b1);
    collect(1'b0, -1);
    after_end();

`ifdef SUM_INV_CHECK_EN
    // corrupt in2 on the 2nd beat; the checker must latch the error
    issue(5'd5, 1'b0);
    collect(1'b0, 1);
    force dut.r_in2 = 4'd0;
    sol_ready = 1'b1;
    @(negedge clk);
    release dut.r_in2;
    chk("chk_err_set", chk_err, 1);
    repeat (40) @(negedge clk);
    chk("chk_err_sticky", chk_err, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
